rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
Parametrised general-purpose register file for the single-cycle and pipelined datapath.
- Successor to the fixed 32x32, 2-read/1-write file.
- Adds configurable width, depth and read-port count, plus a second write port, per-byte write enables, optional hardwired zero register, optional write-to-read bypass and synchronous clear.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
DEPTH, 32, number of registers; power of two, at least 2.
NUM_RD, 2, number of read ports, 1..4.
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
BYPASS, 1, 1 = a read of a register being written this cycle returns the new data.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
rd_addr  in  NUM_RD*AW  packed read addresses; port i uses bits [i*AW +: AW]; AW = clog2(DEPTH)
rd_data  out  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
wr0_en  in  1  write port 0 enable
wr0_addr  in  AW  write port 0 address
wr0_be  in  DATA_W/8  write port 0 byte enables
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable; has priority over port 0
wr1_addr  in  AW  write port 1 address
wr1_be  in  DATA_W/8  write port 1 byte enables
wr1_data  in  DATA_W  write port 1 data

Behaviour:
Reset
- Synchronous and active-high: when rst=1 at a rising clk edge, all DEPTH registers become 0.
- Writes presented in the same cycle as rst are discarded.
- While rst=1 the bypass is disabled: rd_data shows stored contents only.

Reads
- Combinational, zero latency: rd_data[i] is a function of rd_addr[i] and current storage, plus the bypass path when enabled.
- After reset, every read returns 0 until a write lands.

Writes
- Byte lane b of register A updates on the rising edge when wrX_en=1, wrX_addr=A and wrX_be[b]=1; other lanes hold.
- Enable with be all-zero: no state change.

Simultaneous writes
- Same address on both ports: each byte lane takes wr1_data if wr1_be[b]=1, else wr0_data if wr0_be[b]=1, else it holds.
- Different addresses: both writes complete in the same edge.

Zero register
- ZERO_REG=1: register 0 never stores data; reads of address 0 return 0, including through the bypass.
- ZERO_REG=0: register 0 behaves like any other register.

Bypass (BYPASS=1, rst=0)
- A read of the address being written returns the value the register will hold after the edge: merged lanes with port priority applied, unwritten lanes taken from storage.
- BYPASS=0: reads always return pre-edge storage.

Addressing and widths
- No out-of-range addresses are possible because DEPTH is a power of two.
- Address wrap-around is by natural truncation to AW bits.
- All read ports are independent; any number of ports may read the same address.

No handshake, no stall: the block accepts one write per port every cycle.

Decomposition:
- Package rf_pkg:
  - clog2 function;
  - BYTE_W=8 constant;
  - lane-merge function: old, data, be -> merged word;
  - two-port priority merge helper.
- Sub-module rf_read_port, instantiated NUM_RD times via generate:
  - inputs: one address, the storage array view, both write ports, rst;
  - applies zero-register and bypass rules;
  - outputs one DATA_W word.
- Storage and write logic stay in rf_multiport.

Test Plan:
1. Reset clear: preload r5=32'hDEADBEEF; assert rst one cycle with wr0 to r5 active -> next cycle rd_addr=5 reads 0; the write is discarded.
2. Byte enables: r3=32'h11223344; wr0 to r3, be=4'b0101, data=32'hAABBCCDD -> r3=32'h11BB33DD after the edge.
3. Port collision: same cycle, wr0 to r7 with be=4'b1111, data=32'h00000000, and wr1 to r7 with be=4'b0011, data=32'hFFFFFFFF -> r7=32'h0000FFFF.
4. Zero register:
   - ZERO_REG=1: write r0=32'h12345678 -> r0 reads 0 in the write cycle (bypass) and afterwards.
   - ZERO_REG=0 build: r0 reads 32'h12345678 after the edge.
5. Bypass: r9=32'h0; in the same cycle, wr1 to r9 with data=32'hCAFEF00D, be=4'b1100, rd_addr[0]=9 ->
   - BYPASS=1: rd_data[0]=32'hCAFE0000 in that cycle.
   - BYPASS=0: rd_data[0]=0, then 32'hCAFE0000 next cycle.
6. Random regression: 1000 cycles of random addresses, enables and be on NUM_RD=4, DEPTH=16 -> every rd_data matches a reference model, with no mismatches.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and byte-lane merge helpers for the multiport register file.
// Helpers work on a wide fixed word; callers zero-extend and truncate to DATA_W.
package rf_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BYTES  = MAX_DATA_W / BYTE_W;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_BYTES-1:0]  be_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic word_t lane_merge(input word_t old_w, input word_t data_w, input be_t be);
    word_t res;
    res = old_w;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (be[b]) res[b*BYTE_W +: BYTE_W] = data_w[b*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  // Port 1 is applied last so its lanes win on a collision.
  function automatic word_t prio_merge(input word_t old_w,
                                       input word_t d0, input be_t be0,
                                       input word_t d1, input be_t be1);
    return lane_merge(lane_merge(old_w, d0, be0), d1, be1);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage lookup, optional write bypass and
// hardwired-zero handling for register 0.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(DEPTH),
  localparam int NB      = DATA_W / BYTE_W
) (
  input  logic                    i_rst,
  input  logic [AW-1:0]           i_addr,
  input  logic [DEPTH*DATA_W-1:0] i_mem,
  input  logic                    i_wr0_en,
  input  logic [AW-1:0]           i_wr0_addr,
  input  logic [NB-1:0]           i_wr0_be,
  input  logic [DATA_W-1:0]       i_wr0_data,
  input  logic                    i_wr1_en,
  input  logic [AW-1:0]           i_wr1_addr,
  input  logic [NB-1:0]           i_wr1_be,
  input  logic [DATA_W-1:0]       i_wr1_data,
  output logic [DATA_W-1:0]       o_data
);

  logic [DATA_W-1:0] w_regs [DEPTH];
  logic [DATA_W-1:0] w_stored;
  logic [DATA_W-1:0] w_merged;
  logic [NB-1:0]     w_be0;
  logic [NB-1:0]     w_be1;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_view
      assign w_regs[gi] = i_mem[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_stored = w_regs[i_addr];
  assign w_be0    = (i_wr0_en && (i_wr0_addr == i_addr)) ? i_wr0_be : '0;
  assign w_be1    = (i_wr1_en && (i_wr1_addr == i_addr)) ? i_wr1_be : '0;
  assign w_merged = DATA_W'(prio_merge(word_t'(w_stored),
                                       word_t'(i_wr0_data), be_t'(w_be0),
                                       word_t'(i_wr1_data), be_t'(w_be1)));

  always_comb begin
    o_data = w_stored;
    if ((BYPASS != 0) && !i_rst) o_data = w_merged;
    if ((ZERO_REG != 0) && (i_addr == '0)) o_data = '0;
  end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file: NUM_RD combinational read ports, two byte-masked
// write ports (port 1 wins per lane), synchronous clear.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(DEPTH),
  localparam int NB      = DATA_W / BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [AW-1:0]            wr0_addr,
  input  logic [NB-1:0]            wr0_be,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [AW-1:0]            wr1_addr,
  input  logic [NB-1:0]            wr1_be,
  input  logic [DATA_W-1:0]        wr1_data
);

  logic [DEPTH*DATA_W-1:0] w_mem_flat;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] r_word;
      logic [NB-1:0]     w_be0;
      logic [NB-1:0]     w_be1;
      logic [DATA_W-1:0] w_next;

      assign w_be0  = (wr0_en && (wr0_addr == AW'(gi))) ? wr0_be : '0;
      assign w_be1  = (wr1_en && (wr1_addr == AW'(gi))) ? wr1_be : '0;
      assign w_next = DATA_W'(prio_merge(word_t'(r_word),
                                         word_t'(wr0_data), be_t'(w_be0),
                                         word_t'(wr1_data), be_t'(w_be1)));

      // Register 0 stays a constant zero when hardwired.
      always_ff @(posedge clk) begin
        if (rst || ((ZERO_REG != 0) && (gi == 0))) r_word <= '0;
        else                                       r_word <= w_next;
      end

      assign w_mem_flat[gi*DATA_W +: DATA_W] = r_word;
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      rf_read_port #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
      ) u_rd (
        .i_rst     (rst),
        .i_addr    (rd_addr[gi*AW +: AW]),
        .i_mem     (w_mem_flat),
        .i_wr0_en  (wr0_en),
        .i_wr0_addr(wr0_addr),
        .i_wr0_be  (wr0_be),
        .i_wr0_data(wr0_data),
        .i_wr1_en  (wr1_en),
        .i_wr1_addr(wr1_addr),
        .i_wr1_be  (wr1_be),
        .i_wr1_data(wr1_data),
        .o_data    (rd_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_rf_multiport.sv
// Directed checks on default and ZERO_REG=0/BYPASS=0 builds, plus a randomised
// regression of a 4-port, 16-entry build against a behavioural model.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] rd_data_nz;
  logic        wr0_en, wr1_en;
  logic [4:0]  wr0_addr, wr1_addr;
  logic [3:0]  wr0_be, wr1_be;
  logic [31:0] wr0_data, wr1_data;

  logic [15:0]  r4_rd_addr;
  logic [127:0] r4_rd_data;
  logic         r4_wr0_en, r4_wr1_en;
  logic [3:0]   r4_wr0_addr, r4_wr1_addr;
  logic [3:0]   r4_wr0_be, r4_wr1_be;
  logic [31:0]  r4_wr0_data, r4_wr1_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m [16];

  always #5 clk = ~clk;

  rf_multiport u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_be(wr0_be), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_be(wr1_be), .wr1_data(wr1_data)
  );

  rf_multiport #(.ZERO_REG(0), .BYPASS(0)) u_dut_nz (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_be(wr0_be), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_be(wr1_be), .wr1_data(wr1_data)
  );

  rf_multiport #(.DEPTH(16), .NUM_RD(4)) u_dut_r4 (
    .clk(clk), .rst(rst), .rd_addr(r4_rd_addr), .rd_data(r4_rd_data),
    .wr0_en(r4_wr0_en), .wr0_addr(r4_wr0_addr), .wr0_be(r4_wr0_be), .wr0_data(r4_wr0_data),
    .wr1_en(r4_wr1_en), .wr1_addr(r4_wr1_addr), .wr1_be(r4_wr1_be), .wr1_data(r4_wr1_data)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_be = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_be = '0; wr1_data = '0;
  endtask

  task automatic set_wr0(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    wr0_en = 1'b1; wr0_addr = a; wr0_be = be; wr0_data = d;
  endtask

  task automatic set_wr1(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    wr1_en = 1'b1; wr1_addr = a; wr1_be = be; wr1_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); rd_addr = {5'd5, 5'd0};
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (rd_data !== 64'h0) begin
      n_bad++; $display("FAIL reset_state: got %h required %h", rd_data, 64'h0);
    end
    $display("txn reset_state rd_data=%h", rd_data);
    @(negedge clk);
    rst = 1'b0; rd_addr = {5'd0, 5'd5};
    set_wr0(5'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL preload_r5: got %h required %h", rd_data[31:0], 32'hDEADBEEF);
    end
    rst = 1'b1; set_wr0(5'd5, 4'hF, 32'h12345678); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL reset_no_bypass: got %h required %h", rd_data[31:0], 32'hDEADBEEF);
    end
    @(negedge clk);
    rst = 1'b0; idle(); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0) begin
      n_bad++; $display("FAIL reset_clear: got %h required %h", rd_data[31:0], 32'h0);
    end
    n_cmp++;
    if (rd_data_nz[31:0] !== 32'h0) begin
      n_bad++; $display("FAIL reset_clear_nz: got %h required %h", rd_data_nz[31:0], 32'h0);
    end
    $display("txn reset_with_write r5=%h", rd_data[31:0]);
  endtask

  task automatic test_byte_en();
    rd_addr = {5'd0, 5'd3};
    set_wr0(5'd3, 4'hF, 32'h11223344);
    @(negedge clk);
    set_wr0(5'd3, 4'b0101, 32'hAABBCCDD); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h11BB33DD) begin
      n_bad++; $display("FAIL byte_en_bypass: got %h required %h", rd_data[31:0], 32'h11BB33DD);
    end
    n_cmp++;
    if (rd_data_nz[31:0] !== 32'h11223344) begin
      n_bad++; $display("FAIL byte_en_pre_edge_nz: got %h required %h", rd_data_nz[31:0], 32'h11223344);
    end
    @(negedge clk);
    set_wr0(5'd3, 4'b0000, 32'hFFFFFFFF); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h11BB33DD) begin
      n_bad++; $display("FAIL byte_en_zero_be_bypass: got %h required %h", rd_data[31:0], 32'h11BB33DD);
    end
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (rd_data_nz[31:0] !== 32'h11BB33DD) begin
      n_bad++; $display("FAIL byte_en_stored: got %h required %h", rd_data_nz[31:0], 32'h11BB33DD);
    end
    $display("txn byte_en r3=%h", rd_data_nz[31:0]);
  endtask

  task automatic test_collision();
    rd_addr = {5'd0, 5'd7};
    set_wr0(5'd7, 4'hF, 32'h00000000);
    set_wr1(5'd7, 4'b0011, 32'hFFFFFFFF); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0000FFFF) begin
      n_bad++; $display("FAIL collision_bypass: got %h required %h", rd_data[31:0], 32'h0000FFFF);
    end
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (rd_data_nz[31:0] !== 32'h0000FFFF) begin
      n_bad++; $display("FAIL collision_stored: got %h required %h", rd_data_nz[31:0], 32'h0000FFFF);
    end
    set_wr0(5'd10, 4'hF, 32'hA5A5A5A5);
    set_wr1(5'd11, 4'hF, 32'h5A5A5A5A);
    @(negedge clk);
    idle(); rd_addr = {5'd11, 5'd10}; #1;
    n_cmp++;
    if (rd_data !== 64'h5A5A5A5A_A5A5A5A5) begin
      n_bad++; $display("FAIL dual_write: got %h required %h", rd_data, 64'h5A5A5A5A_A5A5A5A5);
    end
    $display("txn collision r7=%h r10/r11=%h", rd_data_nz[31:0], rd_data);
  endtask

  task automatic test_zero_reg();
    rd_addr = {5'd0, 5'd0};
    set_wr0(5'd0, 4'hF, 32'h12345678); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0) begin
      n_bad++; $display("FAIL zero_reg_bypass: got %h required %h", rd_data[31:0], 32'h0);
    end
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (rd_data !== 64'h0) begin
      n_bad++; $display("FAIL zero_reg_after: got %h required %h", rd_data, 64'h0);
    end
    n_cmp++;
    if (rd_data_nz[31:0] !== 32'h12345678) begin
      n_bad++; $display("FAIL zero_reg_off: got %h required %h", rd_data_nz[31:0], 32'h12345678);
    end
    $display("txn zero_reg r0=%h r0_nz=%h", rd_data[31:0], rd_data_nz[31:0]);
  endtask

  task automatic test_bypass();
    rd_addr = {5'd9, 5'd9};
    set_wr1(5'd9, 4'b1100, 32'hCAFEF00D); #1;
    n_cmp++;
    if (rd_data !== 64'hCAFE0000_CAFE0000) begin
      n_bad++; $display("FAIL bypass_on: got %h required %h", rd_data, 64'hCAFE0000_CAFE0000);
    end
    n_cmp++;
    if (rd_data_nz[31:0] !== 32'h0) begin
      n_bad++; $display("FAIL bypass_off_same_cycle: got %h required %h", rd_data_nz[31:0], 32'h0);
    end
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (rd_data_nz[31:0] !== 32'hCAFE0000) begin
      n_bad++; $display("FAIL bypass_off_next_cycle: got %h required %h", rd_data_nz[31:0], 32'hCAFE0000);
    end
    n_cmp++;
    if (rd_data[31:0] !== 32'hCAFE0000) begin
      n_bad++; $display("FAIL bypass_on_next_cycle: got %h required %h", rd_data[31:0], 32'hCAFE0000);
    end
    $display("txn bypass r9=%h", rd_data[31:0]);
  endtask

  function automatic logic [31:0] model_next(input logic [3:0] a);
    logic [31:0] v;
    v = m[a];
    for (int b = 0; b < 4; b++) begin
      if (r4_wr1_en && (r4_wr1_addr == a) && r4_wr1_be[b])
        v[b*8 +: 8] = r4_wr1_data[b*8 +: 8];
      else if (r4_wr0_en && (r4_wr0_addr == a) && r4_wr0_be[b])
        v[b*8 +: 8] = r4_wr0_data[b*8 +: 8];
    end
    return v;
  endfunction

  task automatic test_random();
    logic [31:0] m_nxt [16];
    logic [3:0]  a;
    logic [31:0] exp_v;
    logic [31:0] got_v;
    for (int i = 0; i < 16; i++) m[i] = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rst         = (c == 0) || ($urandom_range(0, 49) == 0);
      r4_wr0_en   = 1'($urandom_range(0, 1));
      r4_wr0_addr = 4'($urandom_range(0, 15));
      r4_wr0_be   = 4'($urandom_range(0, 15));
      r4_wr0_data = $urandom();
      r4_wr1_en   = 1'($urandom_range(0, 1));
      r4_wr1_addr = ($urandom_range(0, 2) == 0) ? r4_wr0_addr : 4'($urandom_range(0, 15));
      r4_wr1_be   = 4'($urandom_range(0, 15));
      r4_wr1_data = $urandom();
      r4_rd_addr  = 16'($urandom());
      if ($urandom_range(0, 2) == 0) r4_rd_addr[3:0] = r4_wr1_addr;
      if ($urandom_range(0, 2) == 0) r4_rd_addr[7:4] = r4_wr0_addr;
      #1;
      for (int p = 0; p < 4; p++) begin
        a     = r4_rd_addr[p*4 +: 4];
        exp_v = (a == 4'd0) ? 32'h0 : (rst ? m[a] : model_next(a));
        got_v = r4_rd_data[p*32 +: 32];
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL random_c%0d_p%0d addr=%0d: got %h required %h", c, p, a, got_v, exp_v);
        end
      end
      $display("txn random c=%0d rst=%0b rd=%h", c, rst, r4_rd_data);
      m_nxt[0] = '0;
      for (int i = 1; i < 16; i++) m_nxt[i] = rst ? 32'h0 : model_next(4'(i));
      @(posedge clk);
      for (int i = 0; i < 16; i++) m[i] = m_nxt[i];
    end
    @(negedge clk);
    rst = 1'b0; r4_wr0_en = 1'b0; r4_wr1_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_addr     = '0;
    r4_rd_addr  = '0;
    r4_wr0_en   = 1'b0; r4_wr0_addr = '0; r4_wr0_be = '0; r4_wr0_data = '0;
    r4_wr1_en   = 1'b0; r4_wr1_addr = '0; r4_wr1_be = '0; r4_wr1_data = '0;
    test_reset();
    test_byte_en();
    test_collision();
    test_zero_reg();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
